// File: rtl/prime_search_ctrl.sv
// -----------------------------------------------------------------------------
// prime_search_ctrl
//
// Sequences an external Miller-Rabin tester to find an RSA prime candidate.
// A seed is forced odd and full-width (LSB and MSB set). Each candidate is
// tested in turn, stepping by 2, until one of these happens:
//   - the tester reports prime,
//   - the attempt limit is reached,
//   - the candidate reaches all-ones, or
//   - a single test times out.
//
// Ports
//   i_clk            system clock, all logic on the rising edge
//   i_rst            synchronous active-low reset
//   i_start          request pulse, only honoured in IDLE
//   i_seed           starting candidate seed
//   i_t_iter         security parameter forwarded to the tester
//   i_max_attempts   maximum number of candidates to test
//   o_busy           high in every state except IDLE
//   o_done           one-cycle completion pulse
//   o_status         00 found, 01 limit, 10 wrap, 11 timeout (held after done)
//   o_prime          last evaluated candidate (the prime when status = 00)
//   o_attempts       number of tests launched in the current/last search
//   o_mr_rst         active-high clear to the tester
//   o_mr_enable      one-cycle launch pulse to the tester
//   o_mr_n           candidate under test
//   o_mr_t           latched t_iter
//   i_mr_done        tester completion
//   i_mr_is_prime    tester verdict, valid while i_mr_done = 1
// -----------------------------------------------------------------------------
module prime_search_ctrl #(
  parameter int WORD_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ATT_WIDTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WORD_WIDTH-1:0] i_seed,
  input  logic [5:0]            i_t_iter,
  input  logic [ATT_WIDTH-1:0]  i_max_attempts,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_status,
  output logic [WORD_WIDTH-1:0] o_prime,
  output logic [ATT_WIDTH-1:0]  o_attempts,
  output logic                  o_mr_rst,
  output logic                  o_mr_enable,
  output logic [WORD_WIDTH-1:0] o_mr_n,
  output logic [5:0]            o_mr_t,
  input  logic                  i_mr_done,
  input  logic                  i_mr_is_prime
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  // Forces the candidate odd and full-width.
  localparam logic [WORD_WIDTH-1:0] ODD_MSB =
    {1'b1, {(WORD_WIDTH-2){1'b0}}, 1'b1};

  localparam logic [1:0] ST_FOUND   = 2'b00;
  localparam logic [1:0] ST_LIMIT   = 2'b01;
  localparam logic [1:0] ST_WRAP    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP   = 3'd1,
    S_CLR    = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_EVAL   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WORD_WIDTH-1:0] r_cand;
  logic [5:0]            r_t;
  logic [ATT_WIDTH-1:0]  r_max;
  logic [ATT_WIDTH-1:0]  r_att;
  logic [TW-1:0]         r_tmo;
  logic                  r_verdict;
  logic                  r_busy;
  logic                  r_done;
  logic [1:0]            r_status;
  logic [WORD_WIDTH-1:0] r_prime;
  logic                  r_mr_rst;
  logic                  r_mr_enable;
  logic [WORD_WIDTH-1:0] r_mr_n;
  logic [5:0]            r_mr_t;

  logic                  w_tmo_hit;
  logic                  w_all_ones;
  logic                  w_eval_stop;
  logic [1:0]            w_eval_status;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and EVAL decisions (priority: prime, wrap, limit).
  always_comb begin
    w_next        = r_state;
    w_tmo_hit     = (r_tmo == TMO_LAST);
    w_all_ones    = &r_cand;
    w_eval_stop   = r_verdict | w_all_ones | (r_att == r_max);
    w_eval_status = ST_LIMIT;
    if (r_verdict) begin
      w_eval_status = ST_FOUND;
    end else if (w_all_ones) begin
      w_eval_status = ST_WRAP;
    end else begin
      w_eval_status = ST_LIMIT;
    end
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_PREP;
        else         w_next = S_IDLE;
      end
      S_PREP: begin
        if (r_max == '0) w_next = S_DONE;
        else             w_next = S_CLR;
      end
      S_CLR:    w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (i_mr_done)      w_next = S_EVAL;
        else if (w_tmo_hit) w_next = S_DONE;
        else                w_next = S_WAIT;
      end
      S_EVAL: begin
        if (w_eval_stop) w_next = S_DONE;
        else             w_next = S_CLR;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; output flags follow the next state so
  // they line up with the state they belong to.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cand      <= '0;
      r_t         <= 6'd0;
      r_max       <= '0;
      r_att       <= '0;
      r_tmo       <= '0;
      r_verdict   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_status    <= 2'b00;
      r_prime     <= '0;
      r_mr_rst    <= 1'b1;
      r_mr_enable <= 1'b0;
      r_mr_n      <= '0;
      r_mr_t      <= 6'd0;
    end else begin
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      r_mr_rst    <= (w_next == S_CLR);
      r_mr_enable <= (w_next == S_LAUNCH);
      // Launch: present operands and count the attempt together with enable.
      if (w_next == S_LAUNCH) begin
        r_mr_n <= r_cand;
        r_mr_t <= r_t;
        r_att  <= r_att + ATT_WIDTH'(1);
        r_tmo  <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cand <= i_seed;
            r_t    <= i_t_iter;
            r_max  <= i_max_attempts;
            r_att  <= '0;
          end
        end
        S_PREP: begin
          r_cand <= r_cand | ODD_MSB;
          if (r_max == '0) r_status <= ST_LIMIT;
        end
        S_WAIT: begin
          if (i_mr_done) begin
            r_verdict <= i_mr_is_prime;
          end else begin
            r_tmo <= r_tmo + TW'(1);
            if (w_tmo_hit) r_status <= ST_TIMEOUT;
          end
        end
        S_EVAL: begin
          r_prime <= r_cand;
          // The wrap rule guarantees this step never runs from all-ones.
          if (w_eval_stop) r_status <= w_eval_status;
          else             r_cand   <= r_cand + WORD_WIDTH'(2);
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_status    = r_status;
  assign o_prime     = r_prime;
  assign o_attempts  = r_att;
  assign o_mr_rst    = r_mr_rst;
  assign o_mr_enable = r_mr_enable;
  assign o_mr_n      = r_mr_n;
  assign o_mr_t      = r_mr_t;

endmodule

// File: doc/prime_search_ctrl.md
Name: prime_search_ctrl

Overview:
- Sequences an external miller_rabin tester to find an RSA prime candidate.
- Takes a seed, forms an odd full-width candidate, and launches a test per candidate.
- Steps the candidate by 2 until the tester reports prime, the attempt limit is reached, the candidate wraps, or a test times out.
- Sits between the key-generation top level and the primality datapath.

Parameters:
- WORD_WIDTH, 32, candidate width; must equal the tester's WORD_WIDTH.
- TIMEOUT_CYCLES, 4096, maximum WAIT cycles per test before abort.
- ATT_WIDTH, 16, width of the attempt limit and attempt counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- seed  input  WORD_WIDTH  starting candidate seed.
- t_iter  input  6  security parameter forwarded to the tester.
- max_attempts  input  ATT_WIDTH  maximum candidates to test.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- status  output  2  00 found, 01 limit, 10 wrap, 11 timeout; valid at done and held.
- prime  output  WORD_WIDTH  last tested candidate; the prime when status=00.
- attempts  output  ATT_WIDTH  number of tests launched.
- mr_rst  output  1  active-high clear to the tester.
- mr_enable  output  1  one-cycle launch pulse to the tester.
- mr_n  output  WORD_WIDTH  candidate under test.
- mr_t  output  6  latched t_iter.
- mr_done  input  1  tester completion.
- mr_is_prime  input  1  tester verdict; valid while mr_done=1.

Behaviour:
- Reset (rst=0 at edge):
  - state=IDLE.
  - busy=0, done=0, status=00, prime=0, attempts=0, mr_enable=0, mr_n=0, mr_t=0.
  - mr_rst=1 for every reset cycle.
  - Reset mid-operation aborts with no done pulse.
- IDLE:
  - mr_rst=0.
  - On start=1: latch seed, t_iter and max_attempts; attempts=0; go to PREP.
  - start while busy is ignored.
- PREP:
  - candidate = seed | 1 | (1<<(WORD_WIDTH-1)).
  - If max_attempts=0: status=01, go to DONE with no launch.
  - Otherwise go to CLR.
- CLR: mr_rst=1 for exactly one cycle; go to LAUNCH.
- LAUNCH:
  - mr_enable=1 for exactly one cycle.
  - mr_n=candidate and mr_t=latched t_iter.
  - attempts += 1; clear the timeout counter; go to WAIT.
- mr_n and mr_t hold stable from LAUNCH until the next CLR or DONE.
- WAIT:
  - Sample mr_done. If 1, capture mr_is_prime and go to EVAL.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES with mr_done still 0: status=11, go to DONE.
  - mr_done is ignored in every state except WAIT.
- EVAL, first matching rule wins:
  1. Verdict prime: status=00.
  2. Candidate all-ones: status=10.
  3. attempts==max_attempts: status=01.
  4. Otherwise candidate+=2, go to CLR.
- In EVAL, prime=candidate in all cases; rules 1–3 go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy falls in the same cycle as the transition to IDLE.
- start asserted in the DONE cycle is ignored; it is accepted on the next IDLE cycle.
- Latency:
  - start sampled at edge 0: PREP at 1, mr_rst at 2, mr_enable at 3.
  - mr_done sampled at edge k gives EVAL at k+1; done pulses at k+2, or the next CLR at k+2.
- Arithmetic: the candidate increment is modulo 2^WORD_WIDTH but never executes from all-ones (wrap rule).

Test Plan:
- WORD_WIDTH=8, behavioural tester (done 5 cycles after enable), seed=0x8A, max=10 -> candidate 139 prime; done, status=00, prime=139, attempts=1; mr_enable at cycle 3.
- seed=0x00, max=10 -> 129 composite then 131 prime; status=00, prime=131, attempts=2; mr_rst pulses twice, each exactly 1 cycle before its mr_enable.
- seed=0x00, max=1 -> status=01, prime=129, attempts=1. Separately, max=0 -> status=01, attempts=0, no mr_enable, done at cycle 2.
- seed=0xFE, max=10 -> 255 composite; status=10, prime=255, attempts=1.
- Tester never asserts mr_done, TIMEOUT_CYCLES=64 -> status=11 after 64 WAIT cycles, attempts=1.
- rst=0 during WAIT -> next edge busy=0, mr_rst=1, attempts=0, no done. start during busy -> ignored, attempts unchanged.
